// File: rtl/work_link_defs.sv
// rtl/work_link_defs.sv - shared work-link constants, UART framing and byte order
package work_link_defs;

    // One work unit is 64 bytes: bytes 0..31 are data2 LSB-first, bytes 32..63 midstate LSB-first
    localparam int WORK_BYTES     = 64;
    localparam int WORK_BITS      = 512;

    // UART 8N1 framing
    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Wire order of the frame: the LSB of the packed word goes out first
    function automatic logic [WORK_BITS-1:0] pack_work(input logic [255:0] midstate,
                                                       input logic [255:0] data2);
        return {midstate, data2};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one UART 8N1 byte: baud timing and START/DATA/STOP sequencing
module uart_tx_byte
    import work_link_defs::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    input  logic bit_in,
    output logic txd,
    output logic shift,
    output logic done
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic          txd_q;
    logic          txd_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign txd     = txd_q;

    // State, baud/bit counters and the registered line value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= UART_STOP_BIT;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            if (state_q == TX_IDLE || bit_end) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + 1'b1;
            end
            if (state_q != TX_DATA) begin
                bit_q <= '0;
            end else if (bit_end) begin
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    // Next state: each phase lasts one bit time; a go during the last stop cycle chains the next byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (go) state_d = TX_START;
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA:  if (bit_end && bit_q == BIT_LAST) state_d = TX_STOP;
            TX_STOP:  if (bit_end) state_d = go ? TX_START : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Outputs: next line value, shift request (one per data bit, taken as the bit is launched) and done
    always_comb begin
        txd_d = txd_q;
        shift = 1'b0;
        done  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                txd_d = go ? UART_START_BIT : UART_STOP_BIT;
            end
            TX_START: begin
                if (bit_end) begin
                    txd_d = bit_in;
                    shift = 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        txd_d = UART_STOP_BIT;
                    end else begin
                        txd_d = bit_in;
                        shift = 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    done  = 1'b1;
                    txd_d = go ? UART_START_BIT : UART_STOP_BIT;
                end
            end
            default: txd_d = UART_STOP_BIT;
        endcase
    end

endmodule

// File: rtl/work_uart_tx.sv
// rtl/work_uart_tx.sv - 512-bit work unit serializer over UART 8N1 (option: WORK_TX_CHECKSUM_EN)
module work_uart_tx
    import work_link_defs::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    input  logic         load,
    output logic         ready,
    output logic         TxD,
    output logic         frame_done
);

`ifdef WORK_TX_CHECKSUM_EN
    localparam int CW          = 7;
    localparam int FRAME_BYTES = WORK_BYTES + 1;
`else
    localparam int CW          = 6;
    localparam int FRAME_BYTES = WORK_BYTES;
`endif
    localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES - 1);

    logic [WORK_BITS-1:0] shreg_q;
    logic [CW-1:0]        byte_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 accept;
    logic                 go;
    logic                 shift;
    logic                 byte_done;
    logic                 last_byte;

    assign accept     = load && ready_q;
    assign last_byte  = (byte_q == LAST_BYTE);
    assign go         = accept || (byte_done && !last_byte);
    assign ready      = ready_q;
    assign frame_done = done_q;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .bit_in  (shreg_q[0]),
        .txd     (TxD),
        .shift   (shift),
        .done    (byte_done)
    );

    // Outer handshake: busy from accept until the last stop bit, then ready and frame_done together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= byte_done && last_byte;
            if (accept) begin
                ready_q <= 1'b0;
            end else if (byte_done && last_byte) begin
                ready_q <= 1'b1;
            end
        end
    end

    // Byte counter: index of the byte on the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_q <= '0;
        end else if (accept) begin
            byte_q <= '0;
        end else if (byte_done && !last_byte) begin
            byte_q <= byte_q + 1'b1;
        end
    end

`ifdef WORK_TX_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       csum_next;

    // After the last work byte the emptied register is reloaded with the checksum byte
    assign csum_next = byte_done && (byte_q == CW'(WORK_BYTES - 1));

    // Running XOR of every work byte as it starts on the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= data2[7:0];
        end else if (byte_done && byte_q < CW'(WORK_BYTES - 1)) begin
            csum_q <= csum_q ^ shreg_q[7:0];
        end
    end
`endif

    // Work shift register: latched on accept, shifted right once per data bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
        end else if (accept) begin
            shreg_q <= pack_work(midstate, data2);
        end else if (shift) begin
            shreg_q <= shreg_q >> 1;
`ifdef WORK_TX_CHECKSUM_EN
        end else if (csum_next) begin
            shreg_q <= {{(WORK_BITS - 8){1'b0}}, csum_q};
`endif
        end
    end

endmodule

// File: tb/tb_work_uart_tx.sv
// tb/tb_work_uart_tx.sv - self-checking bench for work_uart_tx with a UART decoder and byte scoreboard
module tb_work_uart_tx;

    localparam int C = 4;
`ifdef WORK_TX_CHECKSUM_EN
    localparam int FB = 65;
`else
    localparam int FB = 64;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] midstate = '0;
    logic [255:0] data2 = '0;
    logic         load = 1'b0;
    logic         ready;
    logic         TxD;
    logic         frame_done;

    work_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .midstate   (midstate),
        .data2      (data2),
        .load       (load),
        .ready      (ready),
        .TxD        (TxD),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         fd_count = 0;
    int         fd_cyc = 0;
    int         rx_frame_idx = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    int         fstart_q[$];

    typedef struct {
        logic [255:0] ms;
        logic [255:0] d2;
        logic [31:0]  lo4;
        logic [23:0]  hi3;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && frame_done) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
    end

    // UART decoder: first low cycle marks the start bit; bits sampled mid-bit
    initial begin : decoder
        logic [7:0] b;
        logic [7:0] e;
        bit         ok;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset_n && TxD == 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (C / 2) @(negedge clk);
                if (!reset_n) ok = 1'b0;
                else chk("start_bit", {31'd0, TxD}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    if (!reset_n) ok = 1'b0;
                    b[i] = TxD;
                end
                repeat (C) @(negedge clk);
                if (!reset_n) ok = 1'b0;
                else if (ok) chk("stop_bit", {31'd0, TxD}, 32'd1);
                if (ok) begin
                    if (rx_frame_idx == 0) fstart_q.push_back(t0);
                    rx_frame_idx = (rx_frame_idx == FB - 1) ? 0 : rx_frame_idx + 1;
                    rx_log.push_back(b);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, b}, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [255:0] ms, input logic [255:0] d2);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(d2[8*i +: 8]);
            x = x ^ d2[8*i +: 8];
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(ms[8*i +: 8]);
            x = x ^ ms[8*i +: 8];
        end
        if (FB == 65) exp_q.push_back(x);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            #1;
            if (ready) break;
        end
        chk("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    task automatic send(input logic [255:0] ms, input logic [255:0] d2);
        wait_ready();
        midstate = ms;
        data2    = d2;
        load     = 1'b1;
        push_expected(ms, d2);
        @(negedge clk);
        #1;
        chk("ready_low_after_accept", {31'd0, ready}, 32'd0);
        load     = 1'b0;
        midstate = ~ms;
        data2    = ~d2;
    endtask

    task automatic wait_done(input int f0);
        for (int k = 0; k < 4 * FB * 10 * C; k++) begin
            if (fd_count > f0) break;
            @(negedge clk);
            #1;
        end
        chk("frame_done_seen", {31'd0, fd_count > f0}, 32'd1);
    endtask

    task automatic check_frame_end();
        chk("ready_with_done", {31'd0, ready}, 32'd1);
        chk("frame_time", fd_cyc - fstart_q[fstart_q.size() - 1], FB * 10 * C);
        @(negedge clk);
        #1;
        chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    endtask

    initial begin : main
        int f0;
        int n0;
        int lows;
        int fd1;

        vecs[0] = '{ms:  256'h2b3f8126_11223344_55667788_99aabbcc_ddeeff00_0a0b0c0d_0e0f1011_1219c0b5,
                    d2:  256'h80000000_00000000_00000000_00000280_00000000_39f3001b_6b7b8d4d_c14bfc31,
                    lo4: 32'h31fc4bc1, hi3: 24'hb5c019};
        vecs[1] = '{ms:  256'h0,
                    d2:  {256{1'b1}},
                    lo4: 32'hffffffff, hi3: 24'h000000};
        vecs[2] = '{ms:  256'h3f3e3d3c3b3a393837363534333231302f2e2d2c2b2a29282726252423222120,
                    d2:  256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
                    lo4: 32'h00010203, hi3: 24'h202122};

        // Reset and idle line
        repeat (5) @(negedge clk);
        #1;
        chk("reset_txd", {31'd0, TxD}, 32'd1);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        reset_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        chk("idle_no_edges", lows, 0);

        // Table-driven single frames
        for (int v = 0; v < 3; v++) begin
            f0 = fd_count;
            n0 = rx_log.size();
            send(vecs[v].ms, vecs[v].d2);
            wait_done(f0);
            check_frame_end();
            chk("bytes_0_3", {rx_log[n0], rx_log[n0+1], rx_log[n0+2], rx_log[n0+3]}, vecs[v].lo4);
            chk("bytes_32_34", {8'd0, rx_log[n0+32], rx_log[n0+33], rx_log[n0+34]}, {8'd0, vecs[v].hi3});
            chk("scoreboard_empty", exp_q.size(), 0);
        end

        // Busy rejection: loads mid-frame must be ignored
        f0 = fd_count;
        n0 = rx_log.size();
        send(vecs[0].ms, vecs[0].d2);
        repeat (48) @(negedge clk);
        midstate = vecs[2].ms; data2 = vecs[2].d2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (1150) @(negedge clk);
        midstate = vecs[1].ms; data2 = vecs[1].d2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done(f0);
        check_frame_end();
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        chk("busy_no_extra_frame", lows, 0);
        chk("busy_byte_count", rx_log.size() - n0, FB);
        chk("busy_done_count", fd_count - f0, 1);

        // Back-to-back with load held high
        wait_ready();
        f0 = fd_count;
        n0 = rx_log.size();
        midstate = vecs[2].ms; data2 = vecs[2].d2; load = 1'b1;
        push_expected(vecs[2].ms, vecs[2].d2);
        @(negedge clk);
        #1;
        chk("b2b_first_accept", {31'd0, ready}, 32'd0);
        midstate = vecs[0].ms; data2 = vecs[0].d2;
        push_expected(vecs[0].ms, vecs[0].d2);
        wait_done(f0);
        fd1 = fd_cyc;
        @(negedge clk);
        #1;
        chk("b2b_second_accept", {31'd0, ready}, 32'd0);
        load = 1'b0;
        wait_done(f0 + 1);
        check_frame_end();
        // Accepted in the frame_done cycle, so the start bit is on the line one cycle later
        chk("b2b_gap", fstart_q[fstart_q.size() - 1] - fd1, 1);
        chk("b2b_bytes", rx_log.size() - n0, 2 * FB);
        chk("b2b_scoreboard_empty", exp_q.size(), 0);

        // Reset during byte 10 DATA (all-zero work keeps TxD low there)
        n0 = rx_log.size();
        send(256'h0, 256'h0);
        for (int k = 0; k < 2000; k++) begin
            if (rx_log.size() >= n0 + 10) break;
            @(negedge clk);
            #1;
        end
        chk("reached_byte_10", {31'd0, rx_log.size() >= n0 + 10}, 32'd1);
        repeat (2 * C) @(negedge clk);
        #1;
        chk("txd_low_in_data", {31'd0, TxD}, 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_txd", {31'd0, TxD}, 32'd1);
        chk("async_reset_ready", {31'd0, ready}, 32'd1);
        chk("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        exp_q.delete();
        rx_frame_idx = 0;
        f0 = fd_count;
        n0 = rx_log.size();
        send(vecs[0].ms, vecs[0].d2);
        wait_done(f0);
        check_frame_end();
        chk("after_reset_bytes_0_3", {rx_log[n0], rx_log[n0+1], rx_log[n0+2], rx_log[n0+3]}, vecs[0].lo4);
        chk("after_reset_count", rx_log.size() - n0, FB);
        chk("after_reset_scoreboard_empty", exp_q.size(), 0);

`ifdef WORK_TX_CHECKSUM_EN
        // Checksum byte over a single non-zero byte
        f0 = fd_count;
        n0 = rx_log.size();
        send(256'hA5, 256'h0);
        wait_done(f0);
        check_frame_end();
        chk("checksum_count", rx_log.size() - n0, 65);
        chk("checksum_byte", {24'd0, rx_log[n0+64]}, 32'h000000a5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/work_uart_tx.md
# work_uart_tx

Host-side serializer for the miner's work link. It accepts one 512-bit work unit (256-bit midstate plus 256-bit data2) through a load/ready handshake and transmits it as a frame of 64 UART 8N1 bytes on `TxD`. This is the byte stream the miner's serial work receiver reassembles into `midstate` and `data2`. It sits in the controller/loopback FPGA designs and in simulation benches that drive a miner top.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `clk`  input  1: single clock; all state on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `midstate`  input  256: midstate of the work unit; sampled on accept.
- `data2`  input  256: data2 of the work unit (nonce field ignored by miner); sampled on accept.
- `load`  input  1: request to send; accepted when `load && ready`.
- `ready`  output  1: idle, can accept a work unit.
- `TxD`  output  1: UART line, idles high.
- `frame_done`  output  1: one-cycle pulse after the final stop bit of a frame.

## Operation
- Accept: on `load && ready` the block latches `{midstate, data2}` into a 512-bit shift register and clears `ready`.
- Byte order: byte 0 = `data2[7:0]`, byte 31 = `data2[255:248]`, byte 32 = `midstate[7:0]`, byte 63 = `midstate[255:248]`.
- Each byte is sent LSB first.
- States:
  - IDLE: `TxD` = 1, `ready` = 1. On accept, go to START.
  - START: `TxD` = 0 for one bit time, then DATA.
  - DATA: 8 bit times, shifting the register right by 1 each bit time. Then STOP.
  - STOP: `TxD` = 1 for one bit time. If the byte counter is 63, go to IDLE with `frame_done` pulsed; otherwise increment the counter and go to START.
- Counters:
  - Baud counter: width ceil(log2(CLKS_PER_BIT)), counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter: 3 bits.
  - Byte counter: 6 bits, or 7 bits with the checksum option.
- `load` while `ready` = 0 is ignored. The frame in flight is not disturbed and the input is not queued.
- Input buses may change freely after the accept cycle.

## Timing
- Reset values: `ready` = 1, `TxD` = 1, `frame_done` = 0, state IDLE, all counters 0.
- Reset asserted mid-frame forces these values immediately (asynchronously); the partial frame is abandoned.
- `TxD` is registered. The start bit of byte 0 appears the cycle after the accept cycle.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame duration: 640 × CLKS_PER_BIT cycles from the first `TxD` low to the end of the last stop bit, with no idle bits between bytes.
- `ready` and `frame_done` rise in the same cycle, immediately after the last stop-bit cycle.
- A `load` in that same cycle is accepted. Back-to-back frames therefore carry only the single stop bit between them.

## Configuration
- `WORK_TX_CHECKSUM_EN` defined: after byte 63, one extra byte is sent (byte 64). It is the XOR of bytes 0..63, accumulated as bytes are sent. Frame = 65 bytes = 650 × CLKS_PER_BIT cycles. `frame_done` follows byte 64's stop bit.
- Undefined: exactly 64 bytes; no checksum logic is synthesized.

## Structure
- Shared package/header `work_link_defs`:
  - `WORK_BYTES` = 64
  - `WORK_BITS` = 512
  - UART frame constants: start = 0, stop = 1, 8 data bits
  - byte-order definition above
- The miner-side receiver must include the same header.
- One sub-module: `uart_tx_byte`, which holds the baud counter and START/DATA/STOP sequencing for a single byte with a `go`/`done` handshake. `work_uart_tx` owns the 512-bit register, byte counter, checksum and outer handshake.

## Test plan
- Reset idle: hold `reset_n` = 0, release → `TxD` = 1, `ready` = 1, `frame_done` = 0; no `TxD` edges for 1000 cycles.
- Single frame, CLKS_PER_BIT = 4:
  - Stimulus: `midstate` = 256'h2b3f8126…19c0b5, `data2` = 256'h…39f3001b6b7b8d4dc14bfc31, one-cycle `load`.
  - Response: UART-decoded bytes are 31 fc 4b c1 … (data2 LSB first), then b5 c0 19 …; `frame_done` pulses exactly 2560 cycles after the first start-bit edge.
- Busy rejection: pulse `load` with different data at cycles 50 and 1200 of a frame → transmitted bytes unchanged, exactly one frame emitted.
- Back-to-back: `load` held high with two successive work units → second start bit immediately follows first frame's stop bit; 128 bytes decoded in order.
- Reset mid-frame: drop `reset_n` during byte 10's DATA state → `TxD` = 1 and `ready` = 1 without waiting for `clk`. A new `load` then sends a full frame starting at byte 0.
- `WORK_TX_CHECKSUM_EN` with all-zero work except `midstate[7:0]` = 8'hA5 → 65 bytes, byte 64 = 8'hA5, `frame_done` after 2600 cycles.
